// File: rtl/kfib_engine.sv
// K-order Fibonacci engine: iterates a sliding window of the last ORDER terms
// through one K-input adder until the window's newest entry is F(n).
module kfib_engine #(
  parameter int WORDSIZE = 32,
  parameter int NWIDTH   = 8,
  parameter int ORDER    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NWIDTH-1:0]   n,
  output logic                busy,
  output logic                ready,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow,
  output logic [WORDSIZE-1:0] term,
  output logic                term_valid
);

  localparam int SUM_W = WORDSIZE + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NWIDTH-1:0]   n_q, n_d;
  logic [NWIDTH-1:0]   idx_q, idx_d;
  logic [WORDSIZE-1:0] win_q [ORDER];
  logic [WORDSIZE-1:0] win_d [ORDER];
  logic [WORDSIZE-1:0] result_q, result_d;
  logic [WORDSIZE-1:0] term_q, term_d;
  logic                tv_q, tv_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;

  logic                accept, step, finish;
  logic [SUM_W-1:0]    sum;

  assign accept = start && (state_q != S_RUN);
  assign step   = (state_q == S_RUN) && (idx_q < n_q);
  assign finish = (state_q == S_RUN) && !(idx_q < n_q);

  // The single adder: 3 guard bits hold the carry of up to 8 addends.
  always_comb begin
    sum = '0;
    for (int k = 0; k < ORDER; k++) begin
      sum = sum + SUM_W'(win_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  always_comb begin
    n_d      = n_q;
    idx_d    = idx_q;
    win_d    = win_q;
    result_d = result_q;
    term_d   = term_q;
    tv_d     = 1'b0;
    ovf_d    = ovf_q;
    ready_d  = ready_q;
    if (accept) begin
      n_d   = n;
      idx_d = NWIDTH'(ORDER - 1);
      for (int k = 0; k < ORDER; k++) begin
        win_d[k] = '0;
      end
      win_d[ORDER-1] = WORDSIZE'(1);
      ovf_d   = 1'b0;
      ready_d = 1'b0;
    end else if (step) begin
      for (int k = 0; k < ORDER - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[ORDER-1] = sum[WORDSIZE-1:0];
      idx_d  = idx_q + 1'b1;
      term_d = sum[WORDSIZE-1:0];
      tv_d   = 1'b1;
      if (|sum[SUM_W-1:WORDSIZE]) ovf_d = 1'b1;
    end else if (finish) begin
      // Indices below K-1 are seed zeros; the window's newest entry is not F(n) there.
      result_d = (n_q < NWIDTH'(ORDER - 1)) ? '0 : win_q[ORDER-1];
      ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      idx_q    <= '0;
      for (int k = 0; k < ORDER; k++) begin
        win_q[k] <= '0;
      end
      result_q <= '0;
      term_q   <= '0;
      tv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      n_q      <= n_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      result_q <= result_d;
      term_q   <= term_d;
      tv_q     <= tv_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign result     = result_q;
  assign overflow   = ovf_q;
  assign term       = term_q;
  assign term_valid = tv_q;

endmodule

// File: tb/tb_kfib_engine.sv
// Directed bench for kfib_engine: three instances (K=2/W=32, K=3/W=32, K=2/W=8)
// share the control inputs; each vector names which instance it checks.
module tb_kfib_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_in = '0;

  logic        busy0, ready0, ovf0, tv0;
  logic [31:0] res0, term0;
  logic        busy1, ready1, ovf1, tv1;
  logic [31:0] res1, term1;
  logic        busy2, ready2, ovf2, tv2;
  logic [7:0]  res2, term2;

  kfib_engine #(.WORDSIZE(32), .NWIDTH(8), .ORDER(2)) u_fib2 (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .busy(busy0), .ready(ready0),
    .result(res0), .overflow(ovf0), .term(term0), .term_valid(tv0));
  kfib_engine #(.WORDSIZE(32), .NWIDTH(8), .ORDER(3)) u_fib3 (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .busy(busy1), .ready(ready1),
    .result(res1), .overflow(ovf1), .term(term1), .term_valid(tv1));
  kfib_engine #(.WORDSIZE(8), .NWIDTH(8), .ORDER(2)) u_fib2w8 (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .busy(busy2), .ready(ready2),
    .result(res2), .overflow(ovf2), .term(term2), .term_valid(tv2));

  always #5 clk = ~clk;

  int          cur_sel = 0;
  logic        busy_m, ready_m, ovf_m, tv_m;
  logic [31:0] res_m, term_m;

  always_comb begin
    busy_m = busy0; ready_m = ready0; ovf_m = ovf0; tv_m = tv0; res_m = res0; term_m = term0;
    case (cur_sel)
      1: begin busy_m = busy1; ready_m = ready1; ovf_m = ovf1; tv_m = tv1; res_m = res1; term_m = term1; end
      2: begin busy_m = busy2; ready_m = ready2; ovf_m = ovf2; tv_m = tv2;
               res_m = {24'd0, res2}; term_m = {24'd0, term2}; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int     sel;
    int     n;
    longint res;
    bit     ovf;
    int     lat;
    int     pulses;
    bit     poke;
  } vec_t;

  vec_t tbl [12];

  task automatic wait_all_idle();
    int guard = 0;
    while ((busy0 || busy1 || busy2) && guard < 400) begin
      @(posedge clk); #1; guard++;
    end
    check("all_idle_timeout", (busy0 || busy1 || busy2) ? 1 : 0, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          pulses;
    longint      last_term;
    longint      prev_res;
    bit          got;
    cur_sel = v.sel;
    #0;
    prev_res = res_m;
    @(negedge clk);
    start = 1'b1;
    n_in  = 8'(v.n);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; pulses = 0; got = 0; last_term = 0;
    check($sformatf("v%0d_busy_after_accept", idx), busy_m, 1);
    check($sformatf("v%0d_ready_low_after_accept", idx), ready_m, 0);
    check($sformatf("v%0d_result_held", idx), res_m, prev_res);
    while (!got && lat < 400) begin
      if (v.poke && lat == 5) begin
        start = 1'b1;
        n_in  = 8'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (tv_m) begin
        pulses++;
        last_term = term_m;
      end
      if (ready_m) got = 1;
    end
    check($sformatf("v%0d_ready_seen", idx), got, 1);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_result", idx), res_m, v.res);
    check($sformatf("v%0d_overflow", idx), ovf_m, v.ovf);
    check($sformatf("v%0d_busy_done", idx), busy_m, 0);
    check($sformatf("v%0d_term_pulses", idx), pulses, v.pulses);
    if (v.pulses > 0) check($sformatf("v%0d_last_term", idx), last_term, v.res);
    wait_all_idle();
  endtask

  initial begin
    int  seen;
    bit  hit;

    //          sel  n   result ovf lat pulses poke
    tbl[0]  = '{0, 10,   55,    0, 11,  9,    0};
    tbl[1]  = '{0,  0,    0,    0,  2,  0,    0};
    tbl[2]  = '{0,  1,    1,    0,  2,  0,    0};
    tbl[3]  = '{0,  2,    1,    0,  3,  1,    0};
    tbl[4]  = '{1, 10,   81,    0, 10,  8,    0};
    tbl[5]  = '{1,  1,    0,    0,  2,  0,    0};
    tbl[6]  = '{1,  2,    1,    0,  2,  0,    0};
    tbl[7]  = '{2, 13,  233,    0, 14, 12,    0};
    tbl[8]  = '{2, 14,  121,    1, 15, 13,    0};
    tbl[9]  = '{2,  5,    5,    0,  6,  4,    0};
    tbl[10] = '{0, 20, 6765,    0, 21, 19,    1};
    tbl[11] = '{0,  3,    2,    0,  4,  2,    0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_ready", ready0, 0);
    check("rst_result", res0, 0);
    check("rst_term", term0, 0);
    check("rst_term_valid", tv0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_busy_k3", busy1, 0);
    check("rst_result_w8", res2, 0);

    // rst and start on the same edge: reset wins.
    @(negedge clk);
    start = 1'b1;
    n_in  = 8'd5;
    @(posedge clk); #1;
    check("rst_beats_start_busy", busy0, 0);
    check("rst_beats_start_ready", ready0, 0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    check("idle_stays_idle", busy0, 0);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], i);
    end

    // Abort mid-run with reset: no ready afterwards.
    cur_sel = 0;
    @(negedge clk);
    start = 1'b1;
    n_in  = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_running", busy0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_ready", ready0, 0);
    check("abort_term_valid", tv0, 0);
    check("abort_result_cleared", res0, 0);
    hit = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ready0 || busy0) hit = 1;
      seen++;
    end
    check("abort_stays_idle", hit, 0);
    check("abort_cycles_observed", seen, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
